lustre_clock_ctrl: RTL and testbench
====================================

Name: lustre_clock_ctrl

Overview:
- Sequencer for the `init` inputs of the fby register banks in generated Lustre nodes.
- Tracks N_DOM activation domains: the base clock plus one per `when` sub-clock.
- Per domain it decides whether the current instant is that domain's first active instant since reset or since a Lustre restart (`every`).
- It drives `init` (select `init_val`) and `fire` (domain active) for every fby bank in that domain, and keeps a saturating base-instant counter.

Parameters:
- N_DOM, 4, number of activation domains; domain 0 is the base clock.
- CNT_W, 16, width of the base-instant counter.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- step  input  1  a base-clock Lustre instant executes in this cycle.
- act  input  N_DOM  sub-clock condition per domain, sampled only when step=1. act[0] is ignored and treated as 1.
- restart  input  N_DOM  restart request per domain, sampled only when step=1.
- fire  output  N_DOM  domain active in this instant.
- init  output  N_DOM  domain is in its first active instant; selects init_val in the fby banks.
- running  output  N_DOM  domain has completed at least one active instant since its last (re)initialisation.
- tick_count  output  CNT_W  number of completed base instants, saturating.
- tick_ovf  output  1  sticky flag: tick_count has saturated.

Behaviour:
- Per-domain state machine, two states:
  - PENDING: reset value.
  - RUNNING.
- Effective activation: eact[i] = act[i] for i>0; eact[0] = 1.
- fire[i] = step & eact[i]. Combinational, valid in the same cycle as step, so fby banks capture on the following edge.
- init[i] = fire[i] & (state[i]==PENDING | restart[i]). Combinational, zero latency.
- Restart and fire in the same cycle: this instant is the re-initial one, so init[i]=1.
- Transitions, evaluated only when step=1:
  - restart[i]=1 and eact[i]=1: RUNNING (initial instant consumed).
  - restart[i]=1 and eact[i]=0: PENDING. The next active instant is initial.
  - restart[i]=0 and eact[i]=1: RUNNING.
  - restart[i]=0 and eact[i]=0: hold state.
- When step=0: all state holds; fire=0, init=0. act and restart are ignored.
- running[i] = registered (state[i]==RUNNING).
- Domains are independent. Restarting domain i does not affect any other domain or tick_count.
- tick_count:
  - Increments by 1 on each clock edge with step=1, until it reaches all-ones.
  - At all-ones it holds; tick_ovf is set on the edge where a step occurs with tick_count already all-ones.
  - tick_ovf stays set until reset.
- Asynchronous reset (reset=1), at any time including mid-sequence:
  - All states go to PENDING immediately; running=0, tick_count=0, tick_ovf=0.
  - fire and init are forced to 0 while reset is high, regardless of step.
  - The first step after reset deasserts gives init[0]=1.
- Widths: no truncation; tick_count is CNT_W bits and never wraps.
- No X propagation: act and restart are don't-care when step=0.

Test Plan:
- Reset then base instants:
  - Stimulus: reset pulse, then step=1 for 3 cycles, act=0, restart=0.
  - Required: cycle 1 fire=4'b0001, init=4'b0001. Cycles 2–3 init=0. running=4'b0001 from cycle 2. tick_count=3 afterwards.
- Sub-clock first activation:
  - Stimulus: step=1 every cycle, act[2] = 0,0,1,0,1.
  - Required: fire[2] = 0,0,1,0,1. init[2] only in cycle 3. running[2] rises after cycle 3.
- Restart while inactive versus active:
  - Stimulus: domain 1 RUNNING; restart[1]=1 with act[1]=0, then act[1]=1 two cycles later.
  - Required: init[1]=0 in the restart cycle, then 1 at the later activation. running[1] drops after the restart edge.
  - Repeat with restart[1]=1 and act[1]=1 in the same cycle: required init[1]=1 in that cycle, running[1] stays 1.
- Gated steps:
  - Stimulus: step=0 with act=4'b1111, restart=4'b1111 for 5 cycles.
  - Required: fire=0, init=0, all states unchanged, tick_count unchanged.
- Counter saturation with CNT_W=3:
  - Stimulus: 9 steps.
  - Required: tick_count reaches 7 after 7 steps and holds at 7. tick_ovf=1 after the 8th step and stays 1 until reset.
- Asynchronous reset mid-run:
  - Stimulus: assert reset between clock edges while all domains are RUNNING.
  - Required: running=0, tick_count=0, init=0, fire=0 immediately, without waiting for an edge. The next step after release gives init[0]=1.

Source files
------------

// File: rtl/lustre_clock_ctrl.sv
// Init/fire sequencer for the fby register banks of generated Lustre nodes.
// Tracks each activation domain's first active instant and counts base instants.
module lustre_clock_ctrl #(
  parameter int N_DOM = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic [N_DOM-1:0] act,
  input  logic [N_DOM-1:0] restart,
  output logic [N_DOM-1:0] fire,
  output logic [N_DOM-1:0] init,
  output logic [N_DOM-1:0] running,
  output logic [CNT_W-1:0] tick_count,
  output logic             tick_ovf
);

  typedef enum logic {
    PENDING = 1'b0,
    RUNNING = 1'b1
  } dom_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_DOM-1:0] eact;

  // The base clock is always active, whatever act[0] says.
  always_comb begin
    eact    = act;
    eact[0] = 1'b1;
  end

  for (genvar g = 0; g < N_DOM; g++) begin : g_dom
    dom_state_t state;
    dom_state_t state_nxt;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state <= PENDING;
      end else begin
        state <= state_nxt;
      end
    end

    // A restart on an inactive instant re-arms the domain; any active instant consumes the initial one.
    always_comb begin
      state_nxt = state;
      if (step) begin
        if (eact[g]) begin
          state_nxt = RUNNING;
        end else if (restart[g]) begin
          state_nxt = PENDING;
        end
      end
    end

    assign fire[g]    = step & eact[g] & ~reset;
    assign init[g]    = fire[g] & ((state == PENDING) | restart[g]);
    assign running[g] = (state == RUNNING);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_count <= '0;
      tick_ovf   <= 1'b0;
    end else if (step) begin
      if (tick_count == CNT_MAX) begin
        tick_ovf <= 1'b1;
      end else begin
        tick_count <= tick_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lustre_clock_ctrl.sv
// Scoreboard bench for lustre_clock_ctrl: a behavioural model queues the expected
// per-cycle outputs and a monitor compares them against the DUT at each falling edge.
module tb_lustre_clock_ctrl;

  localparam int N_DOM = 4;
  localparam int CNT_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [N_DOM-1:0] fire;
    logic [N_DOM-1:0] init;
    logic [N_DOM-1:0] running;
    int               tick;
    logic             ovf;
  } expect_t;

  logic             clock;
  logic             reset;
  logic             step;
  logic [N_DOM-1:0] act;
  logic [N_DOM-1:0] restart;
  logic [N_DOM-1:0] fire;
  logic [N_DOM-1:0] init;
  logic [N_DOM-1:0] running;
  logic [CNT_W-1:0] tick_count;
  logic             tick_ovf;

  expect_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Model state: which domains have had an active instant since their last (re)initialisation.
  logic [N_DOM-1:0] m_started;
  int               m_count;
  logic             m_ovf;

  lustre_clock_ctrl #(.N_DOM(N_DOM), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .step(step), .act(act), .restart(restart),
    .fire(fire), .init(init), .running(running),
    .tick_count(tick_count), .tick_ovf(tick_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_started = '0;
    m_count   = 0;
    m_ovf     = 1'b0;
  endtask

  // Drives one cycle's inputs just after the rising edge and queues what the DUT must show.
  task automatic applyStimulus(input logic r, input logic s, input logic [N_DOM-1:0] a,
                               input logic [N_DOM-1:0] rs);
    expect_t e;
    logic [N_DOM-1:0] active;
    @(posedge clock);
    #1;
    reset   = r;
    step    = s;
    act     = a;
    restart = rs;
    active  = a | N_DOM'(1);
    if (r) modelReset();
    e.fire    = (!r && s) ? active : '0;
    e.init    = e.fire & (~m_started | rs);
    e.running = m_started;
    e.tick    = m_count;
    e.ovf     = m_ovf;
    exp_q.push_back(e);
    if (!r && s) begin
      for (int i = 0; i < N_DOM; i++) begin
        if (active[i]) m_started[i] = 1'b1;
        else if (rs[i]) m_started[i] = 1'b0;
      end
      if (m_count == CNT_MAX) m_ovf = 1'b1;
      else m_count = m_count + 1;
    end
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("fire", 32'(fire), 32'(e.fire));
        checkOutput("init", 32'(init), 32'(e.init));
        checkOutput("running", 32'(running), 32'(e.running));
        checkOutput("tick_count", 32'(tick_count), 32'(e.tick));
        checkOutput("tick_ovf", 32'(tick_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin : driver
    int drain;
    reset = 1'b1; step = 1'b0; act = '0; restart = '0;
    modelReset();

    // Reset then base instants
    applyStimulus(1, 0, 4'h0, 4'h0);
    applyStimulus(0, 1, 4'h0, 4'h0);
    applyStimulus(0, 1, 4'h0, 4'h0);
    applyStimulus(0, 1, 4'h0, 4'h0);

    // Sub-clock first activation on domain 2
    applyStimulus(0, 1, 4'h0, 4'h0);
    applyStimulus(0, 1, 4'h0, 4'h0);
    applyStimulus(0, 1, 4'h4, 4'h0);
    applyStimulus(0, 1, 4'h0, 4'h0);
    applyStimulus(0, 1, 4'h4, 4'h0);

    // Restart of domain 1 while inactive, then while active
    applyStimulus(1, 0, 4'h0, 4'h0);
    applyStimulus(0, 1, 4'h2, 4'h0);
    applyStimulus(0, 1, 4'h0, 4'h2);
    applyStimulus(0, 1, 4'h0, 4'h0);
    applyStimulus(0, 1, 4'h2, 4'h0);
    applyStimulus(0, 1, 4'h2, 4'h2);
    applyStimulus(0, 1, 4'h0, 4'h0);

    // Gated steps
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 4'hF, 4'hF);

    // Counter saturation
    applyStimulus(1, 0, 4'h0, 4'h0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 1, 4'h0, 4'h0);
    applyStimulus(0, 0, 4'h0, 4'h0);
    applyStimulus(0, 1, 4'h0, 4'h0);

    // Asynchronous reset between edges with every domain running
    applyStimulus(1, 0, 4'h0, 4'h0);
    applyStimulus(0, 1, 4'hF, 4'h0);
    applyStimulus(0, 0, 4'h0, 4'h0);
    @(negedge clock);
    #1;
    checkOutput("pre_reset_running", 32'(running), 32'hF);
    reset = 1'b1;
    step  = 1'b1;
    act   = 4'hF;
    #1;
    checkOutput("async_running", 32'(running), 32'h0);
    checkOutput("async_tick", 32'(tick_count), 32'h0);
    checkOutput("async_fire", 32'(fire), 32'h0);
    checkOutput("async_init", 32'(init), 32'h0);
    modelReset();
    applyStimulus(1, 1, 4'hF, 4'h0);
    applyStimulus(0, 1, 4'h0, 4'h0);

    // Randomised instants with occasional resets
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                    N_DOM'($urandom), N_DOM'($urandom_range(0, 3) == 0 ? $urandom : 0));
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clock);
      drain++;
    end
    #1;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
